requantize: RTL and testbench
=============================

# requantize

Per-lane requantizer between a CNN layer's 32-bit accumulator output and the next layer's 8-bit input. Each of SIZE signed 32-bit lanes is scaled by a power of two (left or right shift, selected by the sign of SHIFT), saturated to signed 8-bit, and registered. It sits at the tail of each conv/FC layer datapath.

## Interface
- SHIFT, default 0: signed integer, range -31..31. Positive means arithmetic left shift by SHIFT; negative means arithmetic right shift by -SHIFT; 0 means saturate only.
- SIZE, default 1: number of parallel lanes, ≥1.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; clears all outputs to 0.
- pixel_in  input  32*SIZE  SIZE signed two's-complement 32-bit lanes; lane i occupies bits [32*i+31 : 32*i], lane 0 at the LSBs.
- pixel_out  output  8*SIZE  SIZE signed 8-bit lanes; lane i occupies bits [8*i+7 : 8*i], and corresponds to input lane i.

## Operation
- Lanes are independent and identical; there is no cross-lane interaction.
- Left shift (SHIFT > 0): compute x·2^SHIFT in at least 32+SHIFT bits, so that no bits are lost before saturation.
- Right shift (SHIFT < 0): arithmetic shift, i.e. floor(x / 2^-SHIFT). Rounding is toward −∞ (−1 >> 3 = −1; −680 >> 3 = −85).
- Saturation: a result > 127 gives 127 (0x7F); a result < −128 gives −128 (0x80); otherwise the low 8 bits of the result.
- Saturation is decided on the full-precision shifted value, never on a truncated one.
- The block has no handshake, valid or enable signal; it is a free-running pipeline.

## Timing
- Latency is 1 cycle: pixel_out reflects the pixel_in value sampled at the previous rising edge of clock.
- Throughput is one vector per cycle.
- When reset is low, pixel_out goes to 0 immediately, with no clock needed, and holds at 0 while reset stays low.
- On the first rising edge after reset is released, pixel_out takes the requantized value of pixel_in.
- Asserting reset mid-stream discards the in-flight vector.
- The only register stage is the output register; no combinational path runs from pixel_in to pixel_out.

## Configuration
- Macro: REQUANTIZE_ROUND_EN.
- Without it (default): right shifts truncate toward −∞ as described above.
- With it: for SHIFT < 0, add 2^(−SHIFT−1) to the full-precision value before shifting (round half up), then saturate.
  - The addition is done without overflow; use ≥33-bit intermediates.
- The macro has no effect on left shifts or on SHIFT = 0.

## Structure
- Shared package holds: IN_W = 32, OUT_W = 8, OUT_MAX = 127, OUT_MIN = −128, and a signed 8-bit pixel typedef.
- Sub-module requantize_lane (combinational shift + saturate, one lane), parameterised by SHIFT.
  - requantize generates SIZE instances of it and owns the output register bank.

## Test plan
- SIZE=4, SHIFT=3, lanes (MSB→LSB) {0, −1, 3150, −5320}, with reset pulsed low then released → one cycle later pixel_out = {0x00, 0xF8, 0x7F, 0x80}.
- Same input, SHIFT=−3 → {0x00, 0xFF, 0x7F, 0x80}.
- SHIFT=3, input {127, −128, 16, −680} → {0x7F, 0x80, 0x7F, 0x80} (16<<3 = 128 saturates).
- SHIFT=−3, input {127, −128, 16, −680} → {0x0F, 0xF0, 0x02, 0xAB}.
- Reset asserted low mid-stream between clock edges → pixel_out = 0 immediately; after release, the first edge loads the current input's result.
- REQUANTIZE_ROUND_EN defined, SHIFT=−3, input {4, 3, −4, −5} → {0x01, 0x00, 0x00, 0xFF}.

Source files
------------

// File: rtl/requantize_pkg.sv
// Shared widths, saturation bounds and pixel type for the requantizer.
package requantize_pkg;
  localparam int IN_W    = 32;
  localparam int OUT_W   = 8;
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  typedef logic signed [OUT_W-1:0] pixel_t;

  // Clamp a full-precision value to the signed 8-bit output range.
  function automatic pixel_t sat8(input logic signed [63:0] v);
    if (v > 64'(OUT_MAX))      sat8 = pixel_t'(OUT_MAX);
    else if (v < 64'(OUT_MIN)) sat8 = pixel_t'(OUT_MIN);
    else                       sat8 = v[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/requantize_lane.sv
// One lane: power-of-two scale then saturate to int8, purely combinational.
// REQUANTIZE_ROUND_EN adds round-half-up on right shifts.
module requantize_lane
  import requantize_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0] pixel_i,
  output pixel_t                 pixel_o
);
  localparam int SH_L = (SHIFT > 0) ? SHIFT  : 0;
  localparam int SH_R = (SHIFT < 0) ? -SHIFT : 0;

`ifdef REQUANTIZE_ROUND_EN
  localparam logic signed [63:0] RND =
    (SH_R > 0) ? (64'sd1 <<< ((SH_R > 0) ? SH_R - 1 : 0)) : 64'sd0;
`else
  localparam logic signed [63:0] RND = 64'sd0;
`endif

  // 64 bits holds x<<31 and x+2^30 without loss, so saturation sees the exact value.
  logic signed [63:0] wide;
  logic signed [63:0] shifted;

  assign wide    = {{(64-IN_W){pixel_i[IN_W-1]}}, pixel_i};
  assign shifted = ((wide + RND) <<< SH_L) >>> SH_R;
  assign pixel_o = sat8(shifted);
endmodule

// File: rtl/requantize.sv
// SIZE-lane int32 -> int8 requantizer with a single output register stage.
// Optional macro REQUANTIZE_ROUND_EN enables round-half-up on right shifts.
module requantize
  import requantize_pkg::*;
#(
  parameter int SHIFT = 0,
  parameter int SIZE  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IN_W*SIZE-1:0]   pixel_in,
  output logic [OUT_W*SIZE-1:0]  pixel_out
);
  logic [SIZE-1:0][OUT_W-1:0] pix_d;
  logic [SIZE-1:0][OUT_W-1:0] pix_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    requantize_lane #(.SHIFT(SHIFT)) u_lane (
      .pixel_i ($signed(pixel_in[IN_W*i +: IN_W])),
      .pixel_o (pix_d[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  assign pixel_out = pix_q;
endmodule

// File: tb/tb_requantize.sv
// Randomized + directed check of requantize at several SHIFT settings, SIZE=4.
module tb_requantize;
  localparam int SIZE = 4;
  localparam int NS = 5;
  localparam int SHIFTS [NS] = '{3, -3, 0, 31, -31};

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [32*SIZE-1:0] pixel_in = '0;
  logic [8*SIZE-1:0]  pix_out [NS];

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  requantize #(.SHIFT(3),   .SIZE(SIZE)) u_p3  (.clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(pix_out[0]));
  requantize #(.SHIFT(-3),  .SIZE(SIZE)) u_m3  (.clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(pix_out[1]));
  requantize #(.SHIFT(0),   .SIZE(SIZE)) u_z   (.clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(pix_out[2]));
  requantize #(.SHIFT(31),  .SIZE(SIZE)) u_p31 (.clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(pix_out[3]));
  requantize #(.SHIFT(-31), .SIZE(SIZE)) u_m31 (.clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_out(pix_out[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // x * 2^s exactly, or floor(x / 2^-s) (optionally round half up), then clamp.
  function automatic logic [7:0] ref_lane(input int x, input int s);
    longint v, d, q;
    v = longint'(x);
    if (s > 0) v = v * (longint'(1) << s);
    else if (s < 0) begin
      d = longint'(1) << (-s);
`ifdef REQUANTIZE_ROUND_EN
      v = v + d / 2;
`endif
      q = v / d;
      if (v < 0 && (v % d) != 0) q = q - 1;
      v = q;
    end
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [31:0] ref_vec(input logic [32*SIZE-1:0] in, input int s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) r[8*i +: 8] = ref_lane(int'(in[32*i +: 32]), s);
    return r;
  endfunction

  function automatic logic [32*SIZE-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check_all(input string tag, input logic [32*SIZE-1:0] in);
    for (int k = 0; k < NS; k++)
      chk($sformatf("%s sh=%0d", tag, SHIFTS[k]), pix_out[k], ref_vec(in, SHIFTS[k]));
  endtask

  task automatic apply(input string tag, input logic [32*SIZE-1:0] v);
    @(negedge clock);
    pixel_in = v;
    @(posedge clock);
    #1;
    check_all(tag, v);
  endtask

  function automatic int rnd_word();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 2000)) - 1000;
      2:       return int'($urandom_range(0, 300)) - 150;
      default: return int'($urandom_range(0, 8)) - 4;
    endcase
  endfunction

  logic [32*SIZE-1:0] v;

  initial begin
    // Reset held from time 0: outputs must be zero, even across an edge.
    pixel_in = pack4(0, -1, 3150, -5320);
    #3;
    for (int k = 0; k < NS; k++) chk("reset_async", pix_out[k], 32'h0);
    @(posedge clock); #1;
    for (int k = 0; k < NS; k++) chk("reset_hold", pix_out[k], 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("tp1 sh=3",  pix_out[0], 32'h00F87F80);
    chk("tp1 sh=-3", pix_out[1], 32'h00FF7F80);
    check_all("tp1", pixel_in);

    v = pack4(127, -128, 16, -680);
    apply("tp2", v);
    chk("tp2 sh=3",  pix_out[0], 32'h7F807F80);
`ifndef REQUANTIZE_ROUND_EN
    chk("tp2 sh=-3", pix_out[1], 32'h0FF002AB);
`else
    v = pack4(4, 3, -4, -5);
    apply("rnd", v);
    chk("rnd sh=-3", pix_out[1], 32'h010000FF);
`endif

    // Range extremes and shift boundaries.
    apply("ext1", pack4(32'h7FFFFFFF, 32'h80000000, 1, -1));
    apply("ext2", pack4(32'h40000000, 32'hC0000000, 0, -2));
    apply("ext3", pack4(128, -129, 127, -128));

    // Mid-stream reset between edges: immediate clear, then first edge reloads.
    v = pack4(100, -7, 55, -900);
    @(negedge clock);
    pixel_in = v;
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < NS; k++) chk("reset_mid", pix_out[k], 32'h0);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    check_all("post_reset", v);

    for (int n = 0; n < 200; n++) begin
      v = pack4(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      apply("rand", v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
